// File: rtl/mem_pkg.sv
// Shared definitions for the byte memory: controller states and default sizes.
package mem_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 13;

  // CLEAR sweeps INIT_VALUE through every word; RUN serves the two ports.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/mem_read_pipe.sv
// LAT-deep valid/data delay line with synchronous flush.
// Handshake: in_valid is a single-cycle pulse with no back-pressure; out_valid
// pulses exactly LAT cycles later. Each data stage loads only behind a valid
// stage, so out_data holds the last returned word while out_valid is low.
module mem_read_pipe #(
  parameter int DATA_W = 8,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [LAT-1:0]    v;
  logic [DATA_W-1:0] d [LAT];

  // Shift valid every cycle; advance data only alongside a valid bit.
  always_ff @(posedge clk) begin
    if (flush) begin
      v <= '0;
      for (int i = 0; i < LAT; i++) d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      if (in_valid) d[0] <= in_data;
      for (int i = 1; i < LAT; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  end

  assign out_valid = v[LAT-1];
  assign out_data  = d[LAT-1];

endmodule

// File: rtl/byte_memory.sv
// Dual-port (fetch read / data read-write) memory with a clear sweep after
// reset. Reads are read-before-write against a same-edge data write.
module byte_memory
  import mem_pkg::*;
#(
  parameter int                      DATA_W     = DEF_DATA_W,
  parameter int                      ADDR_W     = DEF_ADDR_W,
  parameter int                      READ_LAT   = 1,
  parameter logic [DATA_W-1:0]       INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata
);

  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  if (READ_LAT < 1) begin : g_lat_check
    $error("byte_memory: READ_LAT must be at least 1");
  end

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              if_acc;
  logic              d_rd_acc;

  // Controller: sweep every address once after reset, then serve requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          cnt <= cnt + ADDR_W'(1);
          if (cnt == LAST) begin
            state <= ST_RUN;
            busy  <= 1'b0;
          end
        end
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // Single write path: the sweep owns it in CLEAR, the data port in RUN.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = d_addr;
    wr_data = d_wdata;
    if (!rst) begin
      if (state == ST_CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = cnt;
        wr_data = INIT_VALUE;
      end else if (d_req && d_we) begin
        wr_en = 1'b1;
      end
    end
  end

  // Storage array; no reset, contents are rebuilt by the sweep.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Reads are only accepted in RUN and never on a reset edge.
  assign if_acc   = !rst && (state == ST_RUN) && if_req;
  assign d_rd_acc = !rst && (state == ST_RUN) && d_req && !d_we;

  mem_read_pipe #(.DATA_W(DATA_W), .LAT(READ_LAT)) u_if_pipe (
    .clk       (clk),
    .flush     (rst),
    .in_valid  (if_acc),
    .in_data   (mem[if_addr]),
    .out_valid (if_rvalid),
    .out_data  (if_rdata)
  );

  mem_read_pipe #(.DATA_W(DATA_W), .LAT(READ_LAT)) u_d_pipe (
    .clk       (clk),
    .flush     (rst),
    .in_valid  (d_rd_acc),
    .in_data   (mem[d_addr]),
    .out_valid (d_rvalid),
    .out_data  (d_rdata)
  );

endmodule

// File: tb/tb_byte_memory.sv
// Directed bench: dut_a uses READ_LAT=2, dut_b READ_LAT=1; both share inputs.
module tb_byte_memory;

  logic       clk = 1'b0;
  logic       rst;
  logic       if_req;
  logic [3:0] if_addr;
  logic       d_req;
  logic       d_we;
  logic [3:0] d_addr;
  logic [7:0] d_wdata;

  logic       busy_a, if_rvalid_a, d_rvalid_a;
  logic [7:0] if_rdata_a, d_rdata_a;
  logic       busy_b, if_rvalid_b, d_rvalid_b;
  logic [7:0] if_rdata_b, d_rdata_b;

  int checks = 0;
  int errors = 0;
  int n;

  // Clock / reset block
  always #5 clk = ~clk;

  byte_memory #(.DATA_W(8), .ADDR_W(4), .READ_LAT(2), .INIT_VALUE(8'h00)) dut_a (
    .clk(clk), .rst(rst), .busy(busy_a),
    .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid_a), .if_rdata(if_rdata_a),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rvalid(d_rvalid_a), .d_rdata(d_rdata_a)
  );

  byte_memory #(.DATA_W(8), .ADDR_W(4), .READ_LAT(1), .INIT_VALUE(8'h00)) dut_b (
    .clk(clk), .rst(rst), .busy(busy_b),
    .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b)
  );

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
  endtask

  // Count cycles until busy drops on dut_a, bounded.
  task automatic count_busy(output int cycles);
    cycles = 0;
    while (busy_a && cycles < 40) begin
      step();
      cycles++;
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;

    // Reset edge; memory content is undefined (dirty) here.
    step();
    check("rst_busy_a", busy_a, 1);
    check("rst_busy_b", busy_b, 1);
    check("rst_if_rvalid", if_rvalid_a, 0);
    check("rst_d_rvalid", d_rvalid_a, 0);
    check("rst_if_rdata", if_rdata_a, 0);
    check("rst_d_rdata", d_rdata_a, 0);
    rst = 1'b0;

    count_busy(n);
    check("sweep_len", n, 16);
    check("sweep_len_b", busy_b, 0);

    // Read back every address after the sweep.
    for (int i = 0; i < 18; i++) begin
      if_req  = (i < 16);
      if_addr = 4'(i);
      step();
      if (i < 16) begin
        check("clr_b_valid", if_rvalid_b, 1);
        check("clr_b_data", if_rdata_b, 8'h00);
      end
      if (i >= 1 && i <= 16) begin
        check("clr_a_valid", if_rvalid_a, 1);
        check("clr_a_data", if_rdata_a, 8'h00);
      end
      if (i == 17) check("clr_a_drain", if_rvalid_a, 0);
    end
    idle_inputs();

    // Write 5 = AA, then read 5 on the following cycle.
    d_req = 1'b1; d_we = 1'b1; d_addr = 4'd5; d_wdata = 8'hAA;
    step();
    check("wr_no_rvalid_0", d_rvalid_a, 0);
    d_we = 1'b0;
    step();
    check("wr_no_rvalid_1", d_rvalid_a, 0);
    d_req = 1'b0;
    step();
    check("rd5_valid", d_rvalid_a, 1);
    check("rd5_data", d_rdata_a, 8'hAA);
    step();
    check("rd5_valid_drop", d_rvalid_a, 0);
    check("rd5_hold", d_rdata_a, 8'hAA);

    // Same-cycle write 3 = 55 and fetch of 3, then fetch of 3 again.
    d_req = 1'b1; d_we = 1'b1; d_addr = 4'd3; d_wdata = 8'h55;
    if_req = 1'b1; if_addr = 4'd3;
    step();
    d_req = 1'b0; d_we = 1'b0;
    step();
    if_req = 1'b0;
    check("rbw_old_valid", if_rvalid_a, 1);
    check("rbw_old_data", if_rdata_a, 8'h00);
    step();
    check("rbw_new_valid", if_rvalid_a, 1);
    check("rbw_new_data", if_rdata_a, 8'h55);
    step();
    check("rbw_hold", if_rdata_a, 8'h55);

    // Preload 0..3 with 10..13, then back-to-back fetches.
    for (int i = 0; i < 4; i++) begin
      d_req = 1'b1; d_we = 1'b1; d_addr = 4'(i); d_wdata = 8'(8'h10 + i);
      step();
    end
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      if_req  = (i < 4);
      if_addr = 4'(i);
      step();
      if (i < 4) begin
        check("b2b_b_valid", if_rvalid_b, 1);
        check("b2b_b_data", if_rdata_b, 32'(8'h10 + i));
      end else begin
        check("b2b_b_end", if_rvalid_b, 0);
      end
      if (i >= 1 && i <= 4) begin
        check("b2b_a_valid", if_rvalid_a, 1);
        check("b2b_a_data", if_rdata_a, 32'(8'h10 + i - 1));
      end else if (i == 5) begin
        check("b2b_a_end", if_rvalid_a, 0);
      end
    end
    idle_inputs();

    // Fetch 1, then reset next cycle with a write presented on the reset edge.
    if_req = 1'b1; if_addr = 4'd1;
    step();
    rst = 1'b1; if_req = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 4'd2; d_wdata = 8'hFF;
    step();
    check("flush_if_rvalid", if_rvalid_a, 0);
    check("flush_busy", busy_a, 1);
    rst = 1'b0;
    if_req = 1'b1;

    // Writes and fetches held during the sweep are dropped.
    n = 0;
    while (busy_a && n < 40) begin
      if (if_rvalid_a || if_rvalid_b) check("busy_rvalid", {if_rvalid_a, if_rvalid_b}, 0);
      step();
      n++;
    end
    idle_inputs();
    check("resweep_len", n, 16);
    step();
    check("busy_no_rvalid", if_rvalid_a, 0);

    d_req = 1'b1; d_we = 1'b0; d_addr = 4'd2;
    step();
    d_addr = 4'd5;
    step();
    check("drop_rd2_valid", d_rvalid_a, 1);
    check("drop_rd2_data", d_rdata_a, 8'h00);
    d_req = 1'b0;
    step();
    check("clr_rd5_valid", d_rvalid_a, 1);
    check("clr_rd5_data", d_rdata_a, 8'h00);
    step();
    check("final_idle", d_rvalid_a, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_memory.md
BYTE_MEMORY -- requirements
Module: byte_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 8: word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 13: address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter READ_LAT, default 1: read latency in cycles; READ_LAT < 1 SHALL be an elaboration error.
REQ-004 SHALL have parameter INIT_VALUE, default 0: word value written to every location by the clear sweep.
REQ-005 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port busy, output, 1: clear sweep in progress; requests are ignored.
REQ-008 SHALL have port if_req, input, 1: fetch-port read request.
REQ-009 SHALL have port if_addr, input, ADDR_W: fetch-port address.
REQ-010 SHALL have port if_rvalid, output, 1: fetch read data valid.
REQ-011 SHALL have port if_rdata, output, DATA_W: fetch read data.
REQ-012 SHALL have port d_req, input, 1: data-port request.
REQ-013 SHALL have port d_we, input, 1: data-port write when 1, read when 0; qualified by d_req.
REQ-014 SHALL have port d_addr, input, ADDR_W: data-port address.
REQ-015 SHALL have port d_wdata, input, DATA_W: data-port write data.
REQ-016 SHALL have port d_rvalid, output, 1: data-port read data valid.
REQ-017 SHALL have port d_rdata, output, DATA_W: data-port read data.

Function
REQ-018 SHALL implement a two-state machine, CLEAR and RUN.
REQ-019 CLEAR: SHALL write INIT_VALUE to mem[cnt] each cycle and increment cnt; at cnt == DEPTH-1 SHALL go to RUN and drop busy. busy is high for exactly DEPTH cycles after rst deasserts.
REQ-020 RUN: accepted fetch read (if_req=1) SHALL drive if_rvalid=1 exactly READ_LAT cycles later, with if_rdata = mem[if_addr] as sampled at the request edge.
REQ-021 RUN: accepted data read (d_req=1, d_we=0) SHALL follow the same latency rule on d_rvalid/d_rdata.
REQ-022 RUN: accepted data write (d_req=1, d_we=1) SHALL update mem[d_addr] at the request edge and SHALL produce no d_rvalid pulse.
REQ-023 Both ports SHALL accept one request per cycle with no back-pressure; back-to-back reads SHALL return in request order with rvalid high on consecutive cycles.
REQ-024 Same-cycle data write and fetch read to the same address: fetch SHALL return the old data (read-before-write); a read issued on any later cycle SHALL return the new data.
REQ-025 Same-cycle data write and fetch read to different addresses SHALL both complete normally.
REQ-026 Requests while busy=1 SHALL be dropped: no rvalid, no memory change.
REQ-027 if_rdata and d_rdata SHALL hold their last returned value while the matching rvalid is low.

Reset
REQ-028 A clock edge with rst=1 SHALL set busy=1, if_rvalid=0, d_rvalid=0, if_rdata=0, d_rdata=0, cnt=0, state=CLEAR.
REQ-029 Reset mid-operation SHALL flush all in-flight reads (no rvalid after the reset edge) and restart the sweep from address 0.
REQ-030 Requests presented during the rst=1 cycle SHALL be ignored.

Structure
REQ-031 The state enum (CLEAR, RUN) and the default DATA_W/ADDR_W constants SHALL live in the shared package mem_pkg.
REQ-032 A sub-module mem_read_pipe (a READ_LAT-deep valid/data delay line with synchronous flush) SHALL be instantiated once per port.
REQ-033 Storage SHALL be a single array with one write path, which the sweep and the data port share by state.

Verification (ADDR_W=4, READ_LAT=2, INIT_VALUE=8'h00 unless stated)
REQ-034 Dirty memory, rst for 1 cycle -> busy high exactly 16 cycles; reads of addresses 0..15 then return 8'h00.
REQ-035 d write addr 5 = 8'hAA, then d read addr 5 on the next cycle -> d_rvalid=1 two cycles after the read with d_rdata=8'hAA; no d_rvalid for the write.
REQ-036 Same cycle: d write addr 3 = 8'h55 and fetch read addr 3 -> if_rdata=8'h00; a fetch read of addr 3 on the next cycle -> 8'h55.
REQ-037 d write addr 2 = 8'hFF while busy -> dropped; after the sweep, a read of addr 2 returns 8'h00.
REQ-038 Fetch read addr 1, rst asserted on the next cycle -> if_rvalid never pulses; busy is high again for 16 cycles.
REQ-039 Fetch reads of addr 0..3 on consecutive cycles (pre-written 8'h10..8'h13) -> if_rvalid high for 4 consecutive cycles returning 8'h10, 8'h11, 8'h12, 8'h13 in order; repeat with READ_LAT=1.
